puzzle_move_sequencer: RTL

Parametrised successor to the fixed 60-entry puzzle-solution store. It holds one writable solution word per puzzle pattern and, on request, streams that pattern's blank-tile moves one at a time over a valid/ready interface. Moves can be played forward (solve) or in inverted reverse order (scramble). The block also tracks the blank tile's row and column, and aborts with an error on any move that would leave the grid. It sits between the pattern-select/control logic and the tile-display/animation datapath.

---
 rtl/puzzle_move_sequencer_pkg.sv | 24 ++
 rtl/puzzle_solution_ram.sv | 32 +++
 rtl/puzzle_move_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/puzzle_move_sequencer_pkg.sv
// Shared definitions for the puzzle move sequencer: move codes, FSM states, word layout helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package puzzle_move_sequencer_pkg;

  // Blank-tile move codes; the inverse of any move is its bitwise NOT.
  localparam logic [1:0] MV_UP    = 2'b11;
  localparam logic [1:0] MV_DOWN  = 2'b00;
  localparam logic [1:0] MV_LEFT  = 2'b10;
  localparam logic [1:0] MV_RIGHT = 2'b01;

  // Sequencer states, kept as plain constants so older tools and scripts can read them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_PLAY = 2'd2;
  localparam state_t ST_FIN  = 2'd3;

  // Bit offset of move slot idx inside a solution word; move0 sits just below the count field.
  function automatic int move_lsb(input int idx, input int max_moves);
    return 2 * (max_moves - 1 - idx);
  endfunction

endpackage

// File: rtl/puzzle_solution_ram.sv
// Solution word store: one synchronous write port, one registered read port, no reset.
// Latency: read data appears the cycle after raddr is presented.
// Backpressure: none; out-of-range writes are dropped and out-of-range reads hold the last data.
module puzzle_solution_ram #(
  parameter int NUM_PATTERNS = 60,
  parameter int ADDR_W       = 6,
  parameter int WORD_W       = 45
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [NUM_PATTERNS];
  logic [WORD_W-1:0] rdata_q;

  // Storage write and registered read; the read sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < NUM_PATTERNS)) begin
      mem[waddr] <= wdata;
    end
    if (int'(raddr) < NUM_PATTERNS) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/puzzle_move_sequencer.sv
// Streams a stored pattern's blank-tile moves (forward, or inverted in reverse order) and tracks the blank.
// Latency: start at edge 0, word latched in LOAD (cycle 1), first m_valid in cycle 2, then one move per cycle.
// Backpressure: m_valid/m_move/m_last hold while m_ready=0; a move that would leave the grid aborts with err.
module puzzle_move_sequencer
  import puzzle_move_sequencer_pkg::*;
#(
  parameter int NUM_PATTERNS = 60,
  parameter int MAX_MOVES    = 20,
  parameter int CNT_W        = 5,
  parameter int ADDR_W       = 6,
  parameter int ROWS         = 3,
  parameter int COLS         = 3,
  parameter int POS_W        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [CNT_W+2*MAX_MOVES-1:0] wdata,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            pattern,
  input  logic                         reverse,
  input  logic [POS_W-1:0]             start_row,
  input  logic [POS_W-1:0]             start_col,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [1:0]                   m_move,
  output logic                         m_last,
  output logic [POS_W-1:0]             blank_row,
  output logic [POS_W-1:0]             blank_col,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int WORD_W = CNT_W + 2 * MAX_MOVES;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              rev_q, rev_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POS_W-1:0]  row_q, row_d;
  logic [POS_W-1:0]  col_q, col_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic [WORD_W-1:0] ram_rdata;
  logic [CNT_W-1:0]  cnt_raw;
  logic [CNT_W-1:0]  cnt_eff;
  logic [1:0]        cur_move;
  logic              move_ok;
  logic              in_play;

  // The read address follows the pattern input so the word is ready while the FSM sits in LOAD.
  puzzle_solution_ram #(
    .NUM_PATTERNS (NUM_PATTERNS),
    .ADDR_W       (ADDR_W),
    .WORD_W       (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (pattern),
    .rdata (ram_rdata)
  );

  // An oversized count only means "use every slot"; it is clamped rather than flagged.
  assign cnt_raw = ram_rdata[WORD_W-1 -: CNT_W];
  assign cnt_eff = (int'(cnt_raw) > MAX_MOVES) ? CNT_W'(MAX_MOVES) : cnt_raw;

  // Reverse playback presents the inverse move, which is the bitwise NOT of the stored code.
  assign cur_move = 2'(word_q >> move_lsb(int'(idx_q), MAX_MOVES)) ^ {2{rev_q}};
  assign in_play  = (state_q == ST_PLAY);

  // Grid-edge legality of the move about to be presented, judged from the current blank position.
  always_comb begin
    move_ok = 1'b0;
    case (cur_move)
      MV_UP:    move_ok = (int'(row_q) > 0);
      MV_DOWN:  move_ok = (int'(row_q) < ROWS - 1);
      MV_LEFT:  move_ok = (int'(col_q) > 0);
      MV_RIGHT: move_ok = (int'(col_q) < COLS - 1);
      default:  move_ok = 1'b0;
    endcase
  end

  // Sequencer next state: start/latch, load the word, step moves on handshakes, finish or abort.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rev_d   = rev_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (int'(pattern) < NUM_PATTERNS) begin
            state_d = ST_LOAD;
            rev_d   = reverse;
            row_d   = start_row;
            col_d   = start_col;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        word_d  = ram_rdata;
        cnt_d   = cnt_eff;
        idx_d   = rev_q ? (cnt_eff - CNT_W'(1)) : '0;
        state_d = (cnt_eff == '0) ? ST_FIN : ST_PLAY;
      end
      ST_PLAY: begin
        if (!move_ok) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (m_ready) begin
          case (cur_move)
            MV_UP:    row_d = row_q - POS_W'(1);
            MV_DOWN:  row_d = row_q + POS_W'(1);
            MV_LEFT:  col_d = col_q - POS_W'(1);
            default:  col_d = col_q + POS_W'(1);
          endcase
          idx_d = rev_q ? (idx_q - CNT_W'(1)) : (idx_q + CNT_W'(1));
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    last_d = (state_d == ST_PLAY) && (cnt_d == CNT_W'(1));
    done_d = (state_d == ST_FIN);
    busy_d = (state_d != ST_IDLE);
  end

  // State registers; reset drops any playback in progress without a done or err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      rev_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rev_q   <= rev_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign m_valid   = in_play && move_ok;
  assign m_move    = in_play ? cur_move : 2'b00;
  assign m_last    = last_q;
  assign blank_row = row_q;
  assign blank_col = col_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
